decode_stage: RTL and testbench
===============================

# decode_stage

Parametrised RV32I decode stage for the Tomasulo front end. Sits between the fetch unit and the issue/reservation-station dispatch logic. Each accepted instruction word is fully decoded: fields, a sign-extended immediate for every format, register-use flags and an illegal-instruction flag. Results are buffered in a DEPTH-entry FIFO with valid/ready handshakes on both sides and a single-cycle flush for branch mispredict recovery.

## Interface
- XLEN, 32: instruction, PC and immediate width (only 32 supported; the parameter is for package reuse).
- DEPTH, 4: decoded-entry FIFO depth; power of two, at least 2.
- CNT_W, 16: width of the decoded-instruction counter.

- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  drop all buffered entries and any input in the same cycle.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  XLEN  instruction word.
- in_pc  in  XLEN  instruction PC.
- out_valid  out  1  head entry valid.
- out_ready  in  1  dispatch consumes the head.
- out_uop  out  decoded_uop_t  head entry (see Structure).
- occupancy  out  $clog2(DEPTH)+1  entries held.
- decoded_cnt  out  CNT_W  instructions accepted since reset; wraps.

## Operation
- Push when in_valid && in_ready && !flush. Pop when out_valid && out_ready && !flush.
- in_ready = (occupancy < DEPTH). No full-bypass: at full, a same-cycle pop does not enable a push.
- out_uop is driven directly from the head storage entry; there is no combinational path from in_instr to out_uop.
- Decode is combinational on in_instr; the result is written into the tail entry at push.
- Immediate by format; all are sign-extended from inst[31] except U:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
- imm_type: NONE for OP, SYSTEM and FENCE; I for OP-IMM, LOAD and JALR; S for STORE; B for BRANCH; U for LUI and AUIPC; J for JAL.
- uses_rs1: OP, OP-IMM, LOAD, STORE, BRANCH, JALR.
- uses_rs2: OP, STORE, BRANCH.
- writes_rd: OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR, and only when rd != 0.
- illegal is set when any of these holds; an illegal entry still flows through with writes_rd, uses_rs1 and uses_rs2 forced to 0:
  - inst[1:0] != 2'b11;
  - opcode is outside the set above;
  - OP with funct7 not 0x00 or 0x20;
  - 0x20 used with funct3 other than 000 or 101;
  - OP-IMM shifts (funct3 001/101) with an illegal funct7.
- decoded_cnt increments by 1 on every push and wraps modulo 2^CNT_W. Flush does not clear it.

## Timing
- Latency is 1 cycle: an instruction pushed at edge N is visible at out_uop with out_valid=1 after edge N.
- Throughput is 1 instruction per cycle while not full.
- Simultaneous push and pop with 0 < occupancy < DEPTH: occupancy is unchanged, and head/tail pointers wrap modulo DEPTH.
- flush: after the edge, occupancy=0 and out_valid=0; in_ready=1 in the next cycle. The input and any pop in the flush cycle are ignored; out_valid may still be 1 during the flush cycle itself.
- Reset outputs: out_valid=0, in_ready=1 from the cycle after reset, occupancy=0, decoded_cnt=0, out_uop=all-zero (storage cleared).
- While rst=1: in_ready=0. Reset mid-stream discards all entries.
- rst has priority over flush; flush has priority over push and pop.

## Structure
- Package decode_pkg holds:
  - opcode localparams (OPC_LUI=7'b0110111, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_FENCE, OPC_SYSTEM);
  - enum imm_type_e (3 bits: NONE, I, S, B, U, J);
  - struct decoded_uop_t {pc, opcode, rs1, rs2, rd, funct3, funct7, imm, imm_type, uses_rs1, uses_rs2, writes_rd, illegal}.
- Sub-module rv32i_decode_comb: purely combinational instruction-to-decoded_uop_t mapping.
- decode_stage instantiates rv32i_decode_comb and owns the FIFO, pointers, counters and handshake.

## Test plan
- Reset then addi x1,x2,10 (0x00A10093) at pc 0x100 -> next cycle out_valid=1, rs1=2, rd=1, imm=0x0000000A, imm_type=I, writes_rd=1, decoded_cnt=1.
- beq x1,x2,-8 (0xFE208CE3), jal x1,2048 (0x001000EF), lui x1,0x12345 (0x123450B7) back-to-back -> imm values:
  - beq: 0xFFFFFFF8, type B, uses_rs2=1, writes_rd=0;
  - jal: 0x00000800, type J;
  - lui: 0x12345000, type U;
  - all in order.
- out_ready=0 with 6 pushes offered at DEPTH=4 -> in_ready drops after 4 pushes, occupancy=4. Then out_ready=1 -> all 6 instructions emerge in order, with a full-state push/pop blocked.
- Flush at occupancy 3 with in_valid=1 in the same cycle -> occupancy=0 and out_valid=0 next cycle; the flushed-cycle input never appears; decoded_cnt is unchanged by the flush.
- 0x00000000, 0xFFFFFFFF, and add with funct7=0x01 (0x02208033) -> illegal=1, writes_rd=0, uses_rs1=0, uses_rs2=0.
- addi x0,x0,0 -> writes_rd=0, illegal=0. Also: rst asserted mid-stream -> outputs reach their reset values after one edge.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types and constants for the RV32I decode stage: opcode values,
// the immediate-format enum and the decoded micro-op record that travels
// from decode into the dispatch FIFO.
package decode_pkg;

  // Instruction / PC / immediate width carried in the decoded record.
  localparam int XLEN_W = 32;

  // Base-ISA major opcodes (inst[6:0]); all end in 2'b11 (32-bit encodings).
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // funct7 values that are legal on register-register ALU ops.
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  // Which immediate layout an instruction uses.
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  // Fully decoded instruction as held in the FIFO and handed to dispatch.
  typedef struct packed {
    logic [XLEN_W-1:0] pc;
    logic [6:0]        opcode;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [XLEN_W-1:0] imm;
    imm_type_e         imm_type;
    logic              uses_rs1;
    logic              uses_rs2;
    logic              writes_rd;
    logic              illegal;
  } decoded_uop_t;

  // Sign-extend a 12-bit immediate field to the full data width.
  function automatic logic [XLEN_W-1:0] sext12(input logic [11:0] v);
    return {{(XLEN_W-12){v[11]}}, v};
  endfunction

endpackage

// File: rtl/rv32i_decode_comb.sv
// Purely combinational RV32I instruction decoder. Maps one instruction
// word plus its PC to a decoded_uop_t: raw fields, the sign-extended
// immediate for its format, register-use flags and an illegal flag.
module rv32i_decode_comb
  import decode_pkg::*;
(
  input  logic [XLEN_W-1:0] i_instr,
  input  logic [XLEN_W-1:0] i_pc,
  output decoded_uop_t      o_uop
);

  logic [6:0]        w_opcode;
  logic [4:0]        w_rd;
  logic [4:0]        w_rs1;
  logic [4:0]        w_rs2;
  logic [2:0]        w_funct3;
  logic [6:0]        w_funct7;

  logic [XLEN_W-1:0] w_immI;
  logic [XLEN_W-1:0] w_immS;
  logic [XLEN_W-1:0] w_immB;
  logic [XLEN_W-1:0] w_immU;
  logic [XLEN_W-1:0] w_immJ;
  logic [XLEN_W-1:0] w_imm;

  imm_type_e         w_immType;
  logic              w_useRs1;
  logic              w_useRs2;
  logic              w_wrRd;
  logic              w_badOpc;
  logic              w_badFunct;
  logic              w_badLow;
  logic              w_illegal;

  assign w_opcode = i_instr[6:0];
  assign w_rd     = i_instr[11:7];
  assign w_funct3 = i_instr[14:12];
  assign w_rs1    = i_instr[19:15];
  assign w_rs2    = i_instr[24:20];
  assign w_funct7 = i_instr[31:25];

  // Every format's immediate is built in parallel; the format mux picks one.
  assign w_immI = sext12(i_instr[31:20]);
  assign w_immS = sext12({i_instr[31:25], i_instr[11:7]});
  assign w_immB = {{(XLEN_W-13){i_instr[31]}}, i_instr[31], i_instr[7],
                   i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_immU = {i_instr[31:12], 12'b0};
  assign w_immJ = {{(XLEN_W-21){i_instr[31]}}, i_instr[31], i_instr[19:12],
                   i_instr[20], i_instr[30:21], 1'b0};

  // Compressed / reserved low bits are never a valid 32-bit encoding.
  assign w_badLow = (i_instr[1:0] != 2'b11);

  // Per-opcode classification: immediate format, operand usage, funct legality.
  always_comb begin
    w_immType  = IMM_NONE;
    w_useRs1   = 1'b0;
    w_useRs2   = 1'b0;
    w_wrRd     = 1'b0;
    w_badOpc   = 1'b0;
    w_badFunct = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_useRs1 = 1'b1;
        w_useRs2 = 1'b1;
        w_wrRd   = 1'b1;
        if ((w_funct7 != F7_BASE) && (w_funct7 != F7_ALT)) begin
          w_badFunct = 1'b1;
        end
        if ((w_funct7 == F7_ALT) && (w_funct3 != 3'b000) && (w_funct3 != 3'b101)) begin
          w_badFunct = 1'b1;
        end
      end
      OPC_OPIMM: begin
        w_immType = IMM_I;
        w_useRs1  = 1'b1;
        w_wrRd    = 1'b1;
        if ((w_funct3 == 3'b001) && (w_funct7 != F7_BASE)) begin
          w_badFunct = 1'b1;
        end
        if ((w_funct3 == 3'b101) && (w_funct7 != F7_BASE) && (w_funct7 != F7_ALT)) begin
          w_badFunct = 1'b1;
        end
      end
      OPC_LOAD: begin
        w_immType = IMM_I;
        w_useRs1  = 1'b1;
        w_wrRd    = 1'b1;
      end
      OPC_JALR: begin
        w_immType = IMM_I;
        w_useRs1  = 1'b1;
        w_wrRd    = 1'b1;
      end
      OPC_STORE: begin
        w_immType = IMM_S;
        w_useRs1  = 1'b1;
        w_useRs2  = 1'b1;
      end
      OPC_BRANCH: begin
        w_immType = IMM_B;
        w_useRs1  = 1'b1;
        w_useRs2  = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        w_immType = IMM_U;
        w_wrRd    = 1'b1;
      end
      OPC_JAL: begin
        w_immType = IMM_J;
        w_wrRd    = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: begin
        w_immType = IMM_NONE;
      end
      default: begin
        w_badOpc = 1'b1;
      end
    endcase
  end

  assign w_illegal = w_badLow | w_badOpc | w_badFunct;

  // Immediate format mux; formats without an immediate carry zero.
  always_comb begin
    w_imm = '0;
    case (w_immType)
      IMM_I:   w_imm = w_immI;
      IMM_S:   w_imm = w_immS;
      IMM_B:   w_imm = w_immB;
      IMM_U:   w_imm = w_immU;
      IMM_J:   w_imm = w_immJ;
      default: w_imm = '0;
    endcase
  end

  // Assemble the record; illegal entries keep their fields but claim no registers.
  always_comb begin
    o_uop           = '0;
    o_uop.pc        = i_pc;
    o_uop.opcode    = w_opcode;
    o_uop.rs1       = w_rs1;
    o_uop.rs2       = w_rs2;
    o_uop.rd        = w_rd;
    o_uop.funct3    = w_funct3;
    o_uop.funct7    = w_funct7;
    o_uop.imm       = w_imm;
    o_uop.imm_type  = w_immType;
    o_uop.uses_rs1  = w_useRs1 & ~w_illegal;
    o_uop.uses_rs2  = w_useRs2 & ~w_illegal;
    o_uop.writes_rd = w_wrRd & (w_rd != 5'd0) & ~w_illegal;
    o_uop.illegal   = w_illegal;
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes each accepted fetch word and buffers the
// result in a DEPTH-entry FIFO with valid/ready on both sides. Flush drops
// everything buffered plus the same-cycle input; the accepted-instruction
// counter survives flushes and only clears on reset.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_instr,
  input  logic [XLEN-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output decoded_uop_t           out_uop,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [CNT_W-1:0]       decoded_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  decoded_uop_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [OCC_W-1:0] r_count;
  logic [CNT_W-1:0] r_decCnt;

  decoded_uop_t     w_dec;
  logic             w_push;
  logic             w_pop;

  rv32i_decode_comb u_decode (
    .i_instr (in_instr),
    .i_pc    (in_pc),
    .o_uop   (w_dec)
  );

  // No full-bypass: readiness depends on occupancy alone, never on a pop.
  assign in_ready    = ~rst & (r_count < OCC_W'(DEPTH));
  assign out_valid   = (r_count != '0);
  assign out_uop     = r_mem[r_head];
  assign occupancy   = r_count;
  assign decoded_cnt = r_decCnt;

  assign w_push = in_valid & in_ready & ~flush;
  assign w_pop  = out_valid & out_ready & ~flush;

  // Entry storage: cleared on reset, tail entry written with the fresh decode on push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_tail] <= w_dec;
    end
  end

  // Head/tail pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Accepted-instruction counter: counts every push, wraps, ignores flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_decCnt <= '0;
    end else if (w_push) begin
      r_decCnt <= r_decCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios followed by randomized
// traffic, all checked against a behavioural FIFO + decode reference model.
module tb_decode_stage;
  import decode_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_instr;
  logic [31:0]            in_pc;
  logic                   out_valid;
  logic                   out_ready;
  decoded_uop_t           out_uop;
  logic [$clog2(DEPTH):0] occupancy;
  logic [CNT_W-1:0]       decoded_cnt;

  int total = 0;
  int bad   = 0;

  decoded_uop_t     expQ[$];
  logic [CNT_W-1:0] mCnt;

  decode_stage #(.XLEN(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_uop     (out_uop),
    .occupancy   (occupancy),
    .decoded_cnt (decoded_cnt)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Global bound so the bench can never hang.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sign-extend the low n bits of v.
  function automatic logic [31:0] sx(input int unsigned v, input int n);
    int unsigned mask;
    int unsigned m;
    mask = (n >= 32) ? 32'hFFFFFFFF : ((32'd1 << n) - 32'd1);
    m = v & mask;
    if (((m >> (n - 1)) & 1) != 0) return m | ~mask;
    return m;
  endfunction

  // Reference decode computed from the ISA rules with plain arithmetic.
  function automatic decoded_uop_t model(input logic [31:0] w, input logic [31:0] pc);
    decoded_uop_t u;
    logic [6:0]   opc;
    logic [2:0]   f3;
    logic [6:0]   f7;
    bit           isBad;
    int unsigned  x;
    u   = '0;
    x   = w;
    opc = w[6:0];
    f3  = w[14:12];
    f7  = w[31:25];
    u.pc     = pc;
    u.opcode = opc;
    u.rd     = w[11:7];
    u.rs1    = w[19:15];
    u.rs2    = w[24:20];
    u.funct3 = f3;
    u.funct7 = f7;
    isBad = !(opc inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                          7'h13, 7'h33, 7'h0F, 7'h73});
    if (opc == 7'h33) begin
      if (!(f7 inside {7'h00, 7'h20})) isBad = 1;
      if (f7 == 7'h20 && !(f3 inside {3'd0, 3'd5})) isBad = 1;
    end
    if (opc == 7'h13 && f3 == 3'd1 && f7 != 7'h00) isBad = 1;
    if (opc == 7'h13 && f3 == 3'd5 && !(f7 inside {7'h00, 7'h20})) isBad = 1;
    case (opc)
      7'h13, 7'h03, 7'h67: begin
        u.imm_type = IMM_I;
        u.imm = sx(x >> 20, 12);
      end
      7'h23: begin
        u.imm_type = IMM_S;
        u.imm = sx(((x >> 25) << 5) | ((x >> 7) & 31), 12);
      end
      7'h63: begin
        u.imm_type = IMM_B;
        u.imm = sx((((x >> 31) & 1) << 12) | (((x >> 7) & 1) << 11) |
                   (((x >> 25) & 63) << 5) | (((x >> 8) & 15) << 1), 13);
      end
      7'h37, 7'h17: begin
        u.imm_type = IMM_U;
        u.imm = x & 32'hFFFFF000;
      end
      7'h6F: begin
        u.imm_type = IMM_J;
        u.imm = sx((((x >> 31) & 1) << 20) | (((x >> 12) & 255) << 12) |
                   (((x >> 20) & 1) << 11) | (((x >> 21) & 1023) << 1), 21);
      end
      default: begin
        u.imm_type = IMM_NONE;
        u.imm = '0;
      end
    endcase
    u.uses_rs1  = !isBad && (opc inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67});
    u.uses_rs2  = !isBad && (opc inside {7'h33, 7'h23, 7'h63});
    u.writes_rd = !isBad && (w[11:7] != 5'd0) &&
                  (opc inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67});
    u.illegal   = isBad;
    return u;
  endfunction

  function automatic logic [31:0] randInstr();
    logic [6:0]  opcs [11];
    logic [31:0] w;
    int          sel;
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    w    = $urandom;
    sel  = $urandom_range(0, 12);
    if (sel < 11) w[6:0] = opcs[sel];
    if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    return w;
  endfunction

  // One clock: drive at negedge, check visible state against the model, advance.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl, output logic acc);
    logic mRdy;
    logic doPush;
    logic doPop;
    @(negedge clk);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    #1;
    mRdy = (expQ.size() < DEPTH);
    chk("in_ready", in_ready, mRdy);
    chk("out_valid", out_valid, expQ.size() != 0);
    chk("occupancy", occupancy, expQ.size());
    chk("decoded_cnt", decoded_cnt, mCnt);
    if (expQ.size() != 0) chk("out_uop", out_uop, expQ[0]);
    doPush = v && mRdy && !fl;
    doPop  = (expQ.size() != 0) && rdy && !fl;
    @(posedge clk);
    if (fl) begin
      expQ.delete();
    end else begin
      if (doPop) void'(expQ.pop_front());
      if (doPush) begin
        expQ.push_back(model(ins, pc));
        mCnt = mCnt + 1'b1;
      end
    end
    acc = doPush;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expQ.delete();
    mCnt = '0;
    #1;
    chk("rst_occupancy", occupancy, 0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_decoded_cnt", decoded_cnt, 0);
    chk("rst_out_uop", out_uop, 128'd0);
    chk("rst_in_ready_after", in_ready, 1'b1);
  endtask

  logic [31:0] fullList [6];
  logic [31:0] illList  [4];
  logic        acc;
  int          idx;
  logic [CNT_W-1:0] savedCnt;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; mCnt = '0;
    resetDut();

    // addi x1,x2,10 at pc 0x100
    cycle(1, 32'h00A10093, 32'h100, 0, 0, acc);
    #1;
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_rs1", out_uop.rs1, 5'd2);
    chk("addi_rd", out_uop.rd, 5'd1);
    chk("addi_imm", out_uop.imm, 32'h0000000A);
    chk("addi_type", out_uop.imm_type, IMM_I);
    chk("addi_wr", out_uop.writes_rd, 1'b1);
    chk("addi_cnt", decoded_cnt, 1);
    cycle(0, 0, 0, 1, 0, acc);

    // beq / jal / lui back-to-back
    cycle(1, 32'hFE208CE3, 32'h104, 1, 0, acc);
    #1;
    chk("beq_imm", out_uop.imm, 32'hFFFFFFF8);
    chk("beq_type", out_uop.imm_type, IMM_B);
    chk("beq_rs2", out_uop.uses_rs2, 1'b1);
    chk("beq_wr", out_uop.writes_rd, 1'b0);
    cycle(1, 32'h001000EF, 32'h108, 1, 0, acc);
    #1;
    chk("jal_imm", out_uop.imm, 32'h00000800);
    chk("jal_type", out_uop.imm_type, IMM_J);
    cycle(1, 32'h123450B7, 32'h10C, 1, 0, acc);
    #1;
    chk("lui_imm", out_uop.imm, 32'h12345000);
    chk("lui_type", out_uop.imm_type, IMM_U);
    cycle(0, 0, 0, 1, 0, acc);

    // Fill to full with dispatch stalled, then drain; fetch holds until accepted.
    for (int k = 0; k < 6; k++) fullList[k] = 32'h00100093 + (k << 20) + (k << 7);
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      cycle(idx < 6, (idx < 6) ? fullList[idx] : 32'h0, 32'h200 + idx * 4, c >= 6, 0, acc);
      if (acc) idx++;
      if (c == 3) begin
        #1;
        chk("full_occ", occupancy, DEPTH);
        chk("full_in_ready", in_ready, 1'b0);
      end
    end
    chk("full_all_pushed", idx, 6);
    #1;
    chk("full_drained", out_valid, 1'b0);

    // Flush at occupancy 3 with a same-cycle input.
    for (int k = 0; k < 3; k++) cycle(1, 32'h00000013 + (k << 20), 32'h300 + k * 4, 0, 0, acc);
    savedCnt = mCnt;
    cycle(1, 32'h00500293, 32'h30C, 1, 1, acc);
    #1;
    chk("flush_occ", occupancy, 0);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ready", in_ready, 1'b1);
    chk("flush_cnt", decoded_cnt, savedCnt);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 0, acc);

    // Illegal encodings plus addi x0,x0,0.
    illList = '{32'h00000000, 32'hFFFFFFFF, 32'h02208033, 32'h00000013};
    for (int k = 0; k < 4; k++) begin
      cycle(1, illList[k], 32'h400 + k * 4, 1, 0, acc);
      #1;
      chk("ill_flag", out_uop.illegal, k < 3);
      chk("ill_wr", out_uop.writes_rd, 1'b0);
      chk("ill_rs1", out_uop.uses_rs1, k == 3);
      chk("ill_rs2", out_uop.uses_rs2, 1'b0);
    end
    cycle(0, 0, 0, 1, 0, acc);

    // Reset in the middle of traffic.
    cycle(1, 32'h00208033, 32'h500, 0, 0, acc);
    cycle(1, 32'h40208033, 32'h504, 0, 0, acc);
    resetDut();

    // Randomized traffic.
    for (int c = 0; c < 500; c++) begin
      cycle($urandom_range(0, 3) != 0, randInstr(), $urandom & 32'hFFFFFFFC,
            $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0, acc);
    end
    for (int c = 0; c < 6; c++) cycle(0, 0, 0, 1, 0, acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
